// File: rtl/serial_adder.sv
// Bit-serial adder: drives a single full_adder cell LSB-first, one bit per clock.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
`timescale 1ns/1ps

module full_adder (
  input  logic a,
  input  logic b,
  input  logic C_IN,
  output logic out,
  output logic C_OUT
);
  assign out   = a ^ b ^ C_IN;
  assign C_OUT = (a & b) | (C_IN & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
  , output logic           ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, done_q;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             fa_sum_s;
  logic             fa_cout_s;
  logic [WIDTH-1:0] res_shift_s;

  full_adder u_fa (
    .a     (opa_q[0]),
    .b     (opb_q[0]),
    .C_IN  (carry_q),
    .out   (fa_sum_s),
    .C_OUT (fa_cout_s)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_shift_s = fa_sum_s;
    end else begin : g_res_wn
      assign res_shift_s = {fa_sum_s, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = c_in;
          res_d   = {WIDTH{1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        res_d   = res_shift_s;
        carry_d = fa_cout_s;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = res_shift_s;
          c_out_d = fa_cout_s;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q here is the carry into the MSB position.
          ovf_d   = carry_q ^ fa_cout_s;
`endif
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= {WIDTH{1'b0}};
      opb_q   <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: results predicted at start, checked at done.
`timescale 1ns/1ps

module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t golden(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input int c);
    exp_t e;
    logic [W:0] t;
    t = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    e.s   = t[W-1:0];
    e.co  = t[W];
    e.ov  = ta[W-1] ^ tb[W-1] ^ t[W-1] ^ t[W];
    e.cyc = c;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest prediction.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (done) begin
        check_val("done_single", done_prev, 1'b0);
        check_val("busy_at_done", busy, 1'b1);
        if (sb.size() == 0) begin
          check_val("unexpected_done", done, 1'b0);
        end else begin
          e = sb.pop_front();
          check_val("sum", sum, e.s);
          check_val("c_out", c_out, e.co);
          check_val("done_cycle", cyc, e.cyc);
`ifdef SERIAL_ADDER_OVF_EN
          check_val("ovf", ovf, e.ov);
`endif
        end
      end
      done_prev = done;
    end else begin
      done_prev = 1'b0;
    end
  end

  // Called at a negedge while IDLE; returns one negedge later with start dropped.
  task automatic drive_start(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input bit push);
    a = ta;
    b = tb;
    c_in = tc;
    start = 1'b1;
    if (push) sb.push_back(golden(ta, tb, tc, cyc + 1 + W));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    c_in = 1'($urandom);
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 4 * W + 10; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check_val("drain_timeout", sb.size(), 0);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    drive_start(ta, tb, tc, 1'b1);
    wait_drain();
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int i;

    #2;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_sum", sum, '0);
    check_val("rst_cout", c_out, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add with busy-length measurement
    drive_start(8'h5A, 8'h3C, 1'b0, 1'b1);
    busy_cnt = busy ? 1 : 0;
    for (i = 0; i < 30 && busy; i++) begin
      @(negedge clk);
      if (busy) busy_cnt = busy_cnt + 1;
    end
    check_val("busy_cycles", busy_cnt, W + 1);
    check_val("queue_after_op1", sb.size(), 0);

    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1);

    // Start pulse during RUN must be ignored
    drive_start(8'h5A, 8'h3C, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    a = 8'h11;
    b = 8'h22;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    @(negedge clk);
    repeat (3) @(negedge clk);
    check_val("held_sum_after_ignored", sum, 8'h96);
    check_val("idle_after_ignored", busy, 1'b0);

    // Asynchronous reset mid-RUN
    drive_start(8'hC3, 8'h4E, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_sum", sum, '0);
    check_val("midrst_cout", c_out, 1'b0);
    check_val("midrst_busy", busy, 1'b0);
    check_val("midrst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_val("post_rst_busy", busy, 1'b0);
    run_op(8'h01, 8'h02, 1'b0);

    // start held high: back-to-back acceptance in each IDLE cycle
    a = 8'h33;
    b = 8'h44;
    c_in = 1'b1;
    start = 1'b1;
    sb.push_back(golden(8'h33, 8'h44, 1'b1, cyc + 1 + W));
    sb.push_back(golden(8'h33, 8'h44, 1'b1, cyc + 1 + 2 * W + 2));
    for (i = 0; i < 4 * W && sb.size() != 1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    check_val("no_third_accept", busy, 1'b0);

    // Signed overflow corners
    run_op(8'h7F, 8'h01, 1'b0);
    run_op(8'h80, 8'h80, 1'b0);
    run_op(8'h10, 8'h20, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);

    // Random regression
    for (i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    check_val("final_queue_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
